lieat_trap_ctrl: RTL and testbench
==================================

LIEAT_TRAP_CTRL -- requirements
Module: lieat_trap_ctrl

Interface
REQ-001 SHALL have parameter XLEN, 32, datapath/PC width.
REQ-002 SHALL have port clock  in  1  single clock; all state on rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port ex_ecall  in  1  ecall retiring in EX, one-cycle pulse.
REQ-005 SHALL have port ex_mret  in  1  mret retiring in EX, one-cycle pulse.
REQ-006 SHALL have port ex_pc  in  XLEN  PC of the EX instruction.
REQ-007 SHALL have port irq_time  in  1  timer interrupt level from CLINT.
REQ-008 SHALL have port irq_msip  in  1  software interrupt level from CLINT.
REQ-009 SHALL have ports csr_mtie and csr_msie  in  1  enables from the CSR file.
REQ-010 SHALL have ports mtvec_pc and mepc_pc  in  XLEN  trap vector and return PC from the CSR file.
REQ-011 SHALL have port if_hold_req  out  1  request to freeze fetch at an instruction boundary.
REQ-012 SHALL have port if_hold_rsp  in  1  fetch frozen; qualifies the timer trap.
REQ-013 SHALL have ports csr_ecall, csr_mret, csr_msip_interrupt, csr_time_interrupt  out  1  one-cycle commit strobes to the CSR file.
REQ-014 SHALL have port csr_pc  out  XLEN  latched trap PC driven to the CSR file.
REQ-015 SHALL have port pipe_flush  out  1  flush all stages younger than EX.
REQ-016 SHALL have ports redirect_valid out 1, redirect_pc out XLEN, redirect_ready in 1  valid/ready PC redirect to fetch.
REQ-017 SHALL have port ex_stall  out  1  holds EX while the controller is not IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, HOLD, COMMIT, REDIRECT.
REQ-019 SHALL, in IDLE, select by priority ecall > mret > msip (irq_msip & csr_msie) > timer (irq_time & csr_mtie); lower-priority events in the same cycle SHALL be dropped; level interrupts are re-sampled later.
REQ-020 SHALL, on ecall/mret/msip in IDLE, latch kind and ex_pc into csr_pc and go to COMMIT next cycle.
REQ-021 SHALL, on timer in IDLE, go to HOLD and assert if_hold_req from the next cycle until leaving HOLD.
REQ-022 SHALL, in HOLD, go to COMMIT when if_hold_rsp=1; if irq_time&csr_mtie drops first, SHALL return to IDLE with no strobe.
REQ-023 SHALL, in COMMIT, assert exactly one csr_* strobe matching the latched kind, plus pipe_flush, for exactly one cycle, then go to REDIRECT; csr_time_interrupt SHALL be asserted together with if_hold_rsp=1 and if_hold_req=1 in that cycle.
REQ-024 SHALL, in REDIRECT, hold redirect_valid=1 with redirect_pc = mepc_pc for mret, else mtvec_pc, sampled combinationally; it SHALL stay stable until redirect_ready.
REQ-025 SHALL return to IDLE on the cycle after redirect_valid & redirect_ready; redirect may complete in the first REDIRECT cycle.
REQ-026 SHALL drive ex_stall=1 in every state except IDLE; ex_ecall/ex_mret received outside IDLE SHALL be ignored.
REQ-027 SHALL give minimum trap latency of 3 cycles (event, COMMIT, REDIRECT) for ecall/mret/msip.

Reset
REQ-028 SHALL, on reset (including mid-HOLD/COMMIT/REDIRECT), enter IDLE next edge, clear the latched kind and csr_pc to 0, and drive all outputs to 0.
REQ-029 SHALL emit no strobe in the reset cycle or the first cycle after it.

Structure
REQ-030 SHALL place FSM state encoding, trap-kind encoding and priority order in the shared core package with XLEN.
REQ-031 SHALL use the codebase general DFF-with-load-and-reset cells for csr_pc and kind; no sub-module beyond them.

Verification
REQ-032 SHALL cover: ex_ecall with ex_pc=0x80000010, mtvec=0x80001000 -> csr_ecall pulse in cycle+1, redirect_pc=0x80001000 in cycle+2.
REQ-033 SHALL cover: irq_time=1, csr_mtie=1, if_hold_rsp after 4 cycles -> if_hold_req for 5 cycles, then csr_time_interrupt pulse, then redirect to mtvec.
REQ-034 SHALL cover: ex_ecall with irq_msip&csr_msie in the same cycle -> only csr_ecall; msip trapped after return to IDLE.
REQ-035 SHALL cover: ex_mret with mepc=0x80000204, redirect_ready low for 3 cycles -> redirect_valid held 4 cycles with pc 0x80000204.
REQ-036 SHALL cover: irq_time drops during HOLD -> IDLE, no strobe; and reset asserted in REDIRECT -> all outputs 0 next cycle.

Source files
------------

// File: rtl/lieat_trap_ctrl_pkg.sv
// Shared definitions for the trap controller: datapath width, FSM state
// encoding, trap-kind encoding and the event priority order.
package lieat_trap_ctrl_pkg;

    localparam int XLEN   = 32;
    localparam int KIND_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HOLD     = 2'd1,
        ST_COMMIT   = 2'd2,
        ST_REDIRECT = 2'd3
    } trap_state_e;

    // KIND_NONE is the cleared value; the remaining codes are ordered so that
    // strobe index (code - 1) maps onto ecall, mret, msip, timer.
    typedef enum logic [KIND_W-1:0] {
        KIND_NONE  = 3'd0,
        KIND_ECALL = 3'd1,
        KIND_MRET  = 3'd2,
        KIND_MSIP  = 3'd3,
        KIND_TIME  = 3'd4
    } trap_kind_e;

    // Priority order: ecall > mret > msip > timer. Losers are dropped.
    function automatic trap_kind_e pick_trap(input logic ecall,
                                             input logic mret,
                                             input logic msip,
                                             input logic tmr);
        trap_kind_e kind;
        kind = KIND_NONE;
        if (ecall)     kind = KIND_ECALL;
        else if (mret) kind = KIND_MRET;
        else if (msip) kind = KIND_MSIP;
        else if (tmr)  kind = KIND_TIME;
        return kind;
    endfunction

endpackage

// File: rtl/lieat_trap_ctrl_dff.sv
// General-purpose register with synchronous reset to zero and load enable.
module lieat_trap_ctrl_dff #(
    parameter int W = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Reset has priority over load.
    always_ff @(posedge clock) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/lieat_trap_ctrl.sv
// Trap controller: arbitrates ecall/mret/msip/timer events from EX, freezes
// fetch for timer traps, issues one CSR commit strobe plus a pipeline flush,
// then hands the new PC to fetch over a valid/ready redirect channel.
module lieat_trap_ctrl #(
    parameter int XLEN = lieat_trap_ctrl_pkg::XLEN
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            ex_ecall,
    input  logic            ex_mret,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            irq_time,
    input  logic            irq_msip,
    input  logic            csr_mtie,
    input  logic            csr_msie,
    input  logic [XLEN-1:0] mtvec_pc,
    input  logic [XLEN-1:0] mepc_pc,
    output logic            if_hold_req,
    input  logic            if_hold_rsp,
    output logic            csr_ecall,
    output logic            csr_mret,
    output logic            csr_msip_interrupt,
    output logic            csr_time_interrupt,
    output logic [XLEN-1:0] csr_pc,
    output logic            pipe_flush,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    input  logic            redirect_ready,
    output logic            ex_stall
);

    import lieat_trap_ctrl_pkg::*;

    trap_state_e       state_reg;
    trap_state_e       state_next;
    trap_kind_e        idle_kind;
    trap_kind_e        kind_reg;
    logic [KIND_W-1:0] kind_q;
    logic              kind_load;
    logic              pc_load;
    logic              evt_msip;
    logic              evt_time;
    logic              commit_ok;
    logic [3:0]        strobe_vec;

    assign evt_msip  = irq_msip & csr_msie;
    assign evt_time  = irq_time & csr_mtie;
    assign idle_kind = pick_trap(ex_ecall, ex_mret, evt_msip, evt_time);
    assign kind_reg  = trap_kind_e'(kind_q);

    lieat_trap_ctrl_dff #(.W(KIND_W)) u_kind_dff (
        .clock (clock),
        .reset (reset),
        .load  (kind_load),
        .d     (KIND_W'(idle_kind)),
        .q     (kind_q)
    );

    lieat_trap_ctrl_dff #(.W(XLEN)) u_pc_dff (
        .clock (clock),
        .reset (reset),
        .load  (pc_load),
        .d     (ex_pc),
        .q     (csr_pc)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and register-load decisions. A timer trap only captures the
    // PC once fetch is frozen, since EX is stalled and stable by then.
    always_comb begin
        state_next = state_reg;
        kind_load  = 1'b0;
        pc_load    = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                if (idle_kind != KIND_NONE) begin
                    kind_load = 1'b1;
                    if (idle_kind == KIND_TIME) begin
                        state_next = ST_HOLD;
                    end else begin
                        pc_load    = 1'b1;
                        state_next = ST_COMMIT;
                    end
                end
            end
            ST_HOLD: begin
                if (!evt_time) begin
                    state_next = ST_IDLE;
                end else if (if_hold_rsp) begin
                    pc_load    = 1'b1;
                    state_next = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                state_next = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                if (redirect_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Commit strobes are suppressed while reset is asserted so no CSR update
    // can slip out in the reset cycle.
    assign commit_ok = (state_reg == ST_COMMIT) && !reset;

    for (genvar gi = 0; gi < 4; gi++) begin : g_strobe
        assign strobe_vec[gi] = commit_ok && (kind_q == KIND_W'(gi + 1));
    end

    // Output decode from the registered state and latched kind.
    always_comb begin
        csr_ecall          = strobe_vec[0];
        csr_mret           = strobe_vec[1];
        csr_msip_interrupt = strobe_vec[2];
        csr_time_interrupt = strobe_vec[3];
        pipe_flush         = commit_ok;
        ex_stall           = (state_reg != ST_IDLE);
        if_hold_req        = (state_reg == ST_HOLD) ||
                             ((state_reg == ST_COMMIT) && (kind_reg == KIND_TIME));
        redirect_valid     = (state_reg == ST_REDIRECT);
        redirect_pc        = '0;
        if (state_reg == ST_REDIRECT) begin
            redirect_pc = (kind_reg == KIND_MRET) ? mepc_pc : mtvec_pc;
        end
    end

endmodule

// File: tb/tb_lieat_trap_ctrl.sv
// Randomized and directed bench for lieat_trap_ctrl against a transaction-level
// reference model; a simple fetch model answers if_hold_req after a delay.
module tb_lieat_trap_ctrl;

    localparam int XL = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          ex_ecall = 1'b0, ex_mret = 1'b0;
    logic [XL-1:0] ex_pc = '0;
    logic          irq_time = 1'b0, irq_msip = 1'b0;
    logic          csr_mtie = 1'b0, csr_msie = 1'b0;
    logic [XL-1:0] mtvec_pc = '0, mepc_pc = '0;
    logic          if_hold_req, if_hold_rsp = 1'b0;
    logic          csr_ecall, csr_mret, csr_msip_interrupt, csr_time_interrupt;
    logic [XL-1:0] csr_pc;
    logic          pipe_flush, redirect_valid;
    logic [XL-1:0] redirect_pc;
    logic          redirect_ready = 1'b0;
    logic          ex_stall;

    lieat_trap_ctrl #(.XLEN(XL)) dut (
        .clock              (clock),
        .reset              (reset),
        .ex_ecall           (ex_ecall),
        .ex_mret            (ex_mret),
        .ex_pc              (ex_pc),
        .irq_time           (irq_time),
        .irq_msip           (irq_msip),
        .csr_mtie           (csr_mtie),
        .csr_msie           (csr_msie),
        .mtvec_pc           (mtvec_pc),
        .mepc_pc            (mepc_pc),
        .if_hold_req        (if_hold_req),
        .if_hold_rsp        (if_hold_rsp),
        .csr_ecall          (csr_ecall),
        .csr_mret           (csr_mret),
        .csr_msip_interrupt (csr_msip_interrupt),
        .csr_time_interrupt (csr_time_interrupt),
        .csr_pc             (csr_pc),
        .pipe_flush         (pipe_flush),
        .redirect_valid     (redirect_valid),
        .redirect_pc        (redirect_pc),
        .redirect_ready     (redirect_ready),
        .ex_stall           (ex_stall)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: which trap is in flight and where it is in its life.
    // kind: 0 none, 1 ecall, 2 mret, 3 msip, 4 timer.
    bit            m_busy, m_wait_fetch, m_commit, m_redir;
    int            m_kind;
    logic [XL-1:0] m_pc;

    // Fetch model and scenario counters.
    int hold_cnt = 0, rsp_delay = 0;
    bit rand_delay = 1'b0;
    int hr_cnt, rv_cnt, ec_cnt, mr_cnt, ms_cnt, tm_cnt;

    task automatic model_clear();
        m_busy = 0; m_wait_fetch = 0; m_commit = 0; m_redir = 0;
        m_kind = 0; m_pc = '0;
    endtask

    task automatic model_edge();
        if (reset) begin
            model_clear();
        end else if (!m_busy) begin
            if (ex_ecall)                   m_kind = 1;
            else if (ex_mret)               m_kind = 2;
            else if (irq_msip && csr_msie)  m_kind = 3;
            else if (irq_time && csr_mtie)  m_kind = 4;
            else                            m_kind = -1;
            if (m_kind >= 1 && m_kind <= 3) begin
                m_busy = 1; m_commit = 1; m_pc = ex_pc;
            end else if (m_kind == 4) begin
                m_busy = 1; m_wait_fetch = 1;
            end else begin
                m_kind = 0;
            end
        end else if (m_wait_fetch) begin
            if (!(irq_time && csr_mtie)) begin
                m_wait_fetch = 0; m_busy = 0;
            end else if (if_hold_rsp) begin
                m_wait_fetch = 0; m_commit = 1; m_pc = ex_pc;
            end
        end else if (m_commit) begin
            m_commit = 0; m_redir = 1;
        end else if (m_redir && redirect_ready) begin
            m_redir = 0; m_busy = 0;
        end
    endtask

    // One clock cycle: answer fetch hold, compare outputs mid-cycle, then
    // advance the model across the rising edge.
    task automatic step();
        logic [7:0]    exp_ctl, got_ctl;
        logic [XL-1:0] exp_rpc;
        bit            c;
        @(negedge clock);
        if (rand_delay && if_hold_req && hold_cnt == 0) rsp_delay = $urandom_range(0, 5);
        if_hold_rsp = if_hold_req && (hold_cnt >= rsp_delay);
        hold_cnt    = if_hold_req ? hold_cnt + 1 : 0;
        #1;
        c = m_commit && !reset;
        exp_ctl = {m_busy,
                   m_wait_fetch || (m_commit && m_kind == 4),
                   c,
                   c && m_kind == 1, c && m_kind == 2, c && m_kind == 3, c && m_kind == 4,
                   m_redir};
        got_ctl = {ex_stall, if_hold_req, pipe_flush, csr_ecall, csr_mret,
                   csr_msip_interrupt, csr_time_interrupt, redirect_valid};
        exp_rpc = m_redir ? ((m_kind == 2) ? mepc_pc : mtvec_pc) : '0;
        chk("ctl", 64'(got_ctl), 64'(exp_ctl));
        chk("csr_pc", 64'(csr_pc), 64'(m_pc));
        chk("redirect_pc", 64'(redirect_pc), 64'(exp_rpc));
        hr_cnt += int'(if_hold_req);
        rv_cnt += int'(redirect_valid);
        ec_cnt += int'(csr_ecall);
        mr_cnt += int'(csr_mret);
        ms_cnt += int'(csr_msip_interrupt);
        tm_cnt += int'(csr_time_interrupt);
        @(posedge clock);
        #1;
        model_edge();
    endtask

    task automatic quiet();
        ex_ecall = 0; ex_mret = 0; irq_time = 0; irq_msip = 0;
        csr_mtie = 0; csr_msie = 0; redirect_ready = 1; reset = 0;
        hr_cnt = 0; rv_cnt = 0; ec_cnt = 0; mr_cnt = 0; ms_cnt = 0; tm_cnt = 0;
    endtask

    initial begin
        model_clear();
        reset = 1;
        repeat (2) @(posedge clock);
        #1;
        step();                       // reset held: all outputs zero
        quiet();
        step();                       // first cycle after reset

        // ecall -> csr_ecall next cycle, redirect to mtvec the cycle after
        mtvec_pc = 32'h8000_1000; mepc_pc = 32'h8000_0100;
        ex_pc = 32'h8000_0010; ex_ecall = 1;
        step();
        ex_ecall = 0; ex_pc = 32'h0;
        repeat (3) step();
        chk("ecall_strobes", 64'(ec_cnt), 64'd1);

        // timer with fetch freezing after 4 cycles
        quiet(); rsp_delay = 3;
        irq_time = 1; csr_mtie = 1; ex_pc = 32'h8000_0044;
        repeat (6) step();
        irq_time = 0;
        repeat (3) step();
        chk("hold_req_cycles", 64'(hr_cnt), 64'd5);
        chk("time_strobes", 64'(tm_cnt), 64'd1);

        // ecall beats msip in the same cycle; msip taken afterwards
        quiet();
        irq_msip = 1; csr_msie = 1; ex_ecall = 1; ex_pc = 32'h8000_0020;
        step();
        ex_ecall = 0; ex_pc = 32'h8000_0024;
        repeat (4) step();
        irq_msip = 0;
        repeat (3) step();
        chk("ecall_first", 64'(ec_cnt), 64'd1);
        chk("msip_later", 64'(ms_cnt), 64'd1);

        // mret with redirect_ready low for three cycles
        quiet();
        mepc_pc = 32'h8000_0204; ex_pc = 32'h8000_0300; redirect_ready = 0; ex_mret = 1;
        step();
        ex_mret = 0;
        repeat (4) step();
        redirect_ready = 1;
        repeat (2) step();
        chk("redirect_hold", 64'(rv_cnt), 64'd4);
        chk("mret_strobes", 64'(mr_cnt), 64'd1);

        // timer drops during HOLD: back to IDLE, no strobe
        quiet(); rsp_delay = 10;
        irq_time = 1; csr_mtie = 1;
        repeat (3) step();
        irq_time = 0;
        repeat (3) step();
        chk("drop_no_strobe", 64'(tm_cnt + ec_cnt + mr_cnt + ms_cnt), 64'd0);

        // reset while in REDIRECT
        quiet(); redirect_ready = 0; ex_ecall = 1; ex_pc = 32'h8000_0400;
        step();
        ex_ecall = 0;
        repeat (2) step();
        reset = 1;
        step();
        reset = 0;
        repeat (2) step();

        // randomized traffic
        quiet(); rand_delay = 1;
        for (int i = 0; i < 3000; i++) begin
            reset          = ($urandom_range(0, 99) == 0);
            ex_ecall       = ($urandom_range(0, 9) == 0);
            ex_mret        = ($urandom_range(0, 9) == 0);
            ex_pc          = $urandom;
            if ($urandom_range(0, 19) == 0) irq_time = ~irq_time;
            if ($urandom_range(0, 19) == 0) irq_msip = ~irq_msip;
            if ($urandom_range(0, 29) == 0) csr_mtie = ~csr_mtie;
            if ($urandom_range(0, 29) == 0) csr_msie = ~csr_msie;
            if ($urandom_range(0, 49) == 0) mtvec_pc = $urandom;
            if ($urandom_range(0, 49) == 0) mepc_pc = $urandom;
            redirect_ready = 1'($urandom_range(0, 1));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
